// File: rtl/rsa_modexp.sv
// ============================================================================
// Module   : rsa_modexp
// Purpose  : Right-to-left binary modular exponentiation, cypher = indata^inExp
//            mod inMod, using two interleaved shift-add modular multipliers.
// Options  : RSA_EARLY_EXIT_EN - finish as soon as the remaining exponent is 0.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rsa_modexp #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     indata,
  input  logic [EXP_WIDTH-1:0] inExp,
  input  logic [WIDTH-1:0]     inMod,
  input  logic                 ds,
  input  logic                 abort,
  output logic [WIDTH-1:0]     cypher,
  output logic                 ready,
  output logic                 busy,
  output logic                 err
);

  localparam int c_bw = $clog2(WIDTH + 1);
  localparam int c_sw = $clog2(EXP_WIDTH + 1);
  localparam logic [c_bw-1:0] c_bit_last  = c_bw'(WIDTH - 1);
  localparam logic [c_sw-1:0] c_step_last = c_sw'(EXP_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state, w_next_state;

  logic [WIDTH-1:0]     r_mod, r_base, r_result, r_shift, r_cypher;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [WIDTH+1:0]     r_acc_mul, r_acc_sq;
  logic [c_bw-1:0]      r_bitcnt;
  logic [c_sw-1:0]      r_stepcnt;
  logic                 r_bad, r_err;

  logic                 w_illegal, w_bit, w_step_end, w_run_done, w_exp_zero;
  logic [WIDTH+1:0]     w_mod1, w_mod2, w_sum_mul, w_sum_sq, w_red_mul, w_red_sq;

  // t < 3*m because acc < m and the addend < m, so two trial subtractions suffice
  function automatic logic [WIDTH+1:0] reduce(input logic [WIDTH+1:0] t,
                                              input logic [WIDTH+1:0] m1,
                                              input logic [WIDTH+1:0] m2);
    if (t >= m2)      return t - m2;
    else if (t >= m1) return t - m1;
    else              return t;
  endfunction

  assign w_mod1     = {2'b00, r_mod};
  assign w_mod2     = {1'b0, r_mod, 1'b0};
  assign w_bit      = r_shift[WIDTH-1];
  assign w_sum_mul  = (r_acc_mul << 1) + (w_bit ? {2'b00, r_result} : '0);
  assign w_sum_sq   = (r_acc_sq << 1) + (w_bit ? {2'b00, r_base} : '0);
  assign w_red_mul  = reduce(w_sum_mul, w_mod1, w_mod2);
  assign w_red_sq   = reduce(w_sum_sq, w_mod1, w_mod2);
  assign w_illegal  = (r_mod < WIDTH'(2)) || (r_base >= r_mod);
  assign w_step_end = (r_bitcnt == c_bit_last);
  assign w_exp_zero = (r_exp == '0);

`ifdef RSA_EARLY_EXIT_EN
  assign w_run_done = w_step_end &&
                      ((r_stepcnt == c_step_last) || (r_exp[EXP_WIDTH-1:1] == '0));
`else
  assign w_run_done = w_step_end && (r_stepcnt == c_step_last);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (ds && !abort) w_next_state = S_CHECK;
      S_CHECK: begin
        if (abort)          w_next_state = S_IDLE;
        else if (w_illegal) w_next_state = S_DONE;
`ifdef RSA_EARLY_EXIT_EN
        else if (w_exp_zero) w_next_state = S_DONE;
`endif
        else                w_next_state = S_RUN;
      end
      S_RUN: begin
        if (abort)           w_next_state = S_IDLE;
        else if (w_run_done) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mod     <= '0;
      r_base    <= '0;
      r_exp     <= '0;
      r_result  <= '0;
      r_shift   <= '0;
      r_acc_mul <= '0;
      r_acc_sq  <= '0;
      r_bitcnt  <= '0;
      r_stepcnt <= '0;
      r_bad     <= 1'b0;
      r_cypher  <= '0;
      r_err     <= 1'b0;
    end else if (abort && (r_state != S_IDLE)) begin
      r_cypher <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ds && !abort) begin
            r_base <= indata;
            r_exp  <= inExp;
            r_mod  <= inMod;
          end
        end
        S_CHECK: begin
          r_bad     <= w_illegal;
          r_result  <= w_illegal ? '0 : WIDTH'(1);
          r_shift   <= r_base;
          r_acc_mul <= '0;
          r_acc_sq  <= '0;
          r_bitcnt  <= '0;
          r_stepcnt <= '0;
        end
        S_RUN: begin
          if (w_step_end) begin
            if (r_exp[0]) r_result <= w_red_mul[WIDTH-1:0];
            r_base    <= w_red_sq[WIDTH-1:0];
            r_shift   <= w_red_sq[WIDTH-1:0];
            r_exp     <= r_exp >> 1;
            r_acc_mul <= '0;
            r_acc_sq  <= '0;
            r_bitcnt  <= '0;
            r_stepcnt <= r_stepcnt + 1'b1;
          end else begin
            r_shift   <= r_shift << 1;
            r_acc_mul <= w_red_mul;
            r_acc_sq  <= w_red_sq;
            r_bitcnt  <= r_bitcnt + 1'b1;
          end
        end
        S_DONE: begin
          r_cypher <= r_result;
          r_err    <= r_bad;
        end
        default: ;
      endcase
    end
  end

  assign cypher = r_cypher;
  assign err    = r_err;
  assign ready  = (r_state == S_IDLE);
  assign busy   = ~ready;

endmodule

`default_nettype wire
